// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the instruction_set_model CPU: instruction and data
// memories, CPU hold/release control and a valid/ready program loader.
module cpu_mem_responder #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ADDRSIZE = 12,
  parameter int unsigned IDEPTH   = 256,
  parameter int unsigned DDEPTH   = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDRSIZE-1:0] mem_addr,
  input  logic [0:WIDTH-1]    mem_wdata,
  input  logic                mem_ctrl,
  output logic [0:WIDTH-1]    mem_rdata,
  input  logic [ADDRSIZE-1:0] ins_addr,
  output logic [0:WIDTH-1]    ins_data,
  input  logic                ld_start,
  input  logic                ld_valid,
  input  logic [0:WIDTH-1]    ld_data,
  input  logic                ld_last,
  output logic                ld_ready,
  input  logic                go,
  output logic                cpu_rst,
  output logic [ADDRSIZE:0]   load_count,
  output logic [15:0]         wr_count,
  output logic                oob_err,
  output logic                ld_ovf
);

  localparam int unsigned IAW = $clog2(IDEPTH);
  localparam int unsigned DAW = $clog2(DDEPTH);
  localparam int unsigned CW  = ADDRSIZE + 1;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e            state_q;
  logic              cpu_rst_q;
  logic              ld_ready_q;
  logic [CW-1:0]     load_count_q;
  logic [15:0]       wr_count_q;
  logic              oob_err_q;
  logic              ld_ovf_q;

  logic [0:WIDTH-1]  imem_q [IDEPTH];
  logic [0:WIDTH-1]  dmem_q [DDEPTH];

  logic              run_c;
  logic              ins_hit_c;
  logic              mem_hit_c;
  logic              accept_c;
  logic              last_slot_c;
  logic              dmem_we_c;

  assign run_c       = (state_q == ST_RUN);
  assign ins_hit_c   = {1'b0, ins_addr} < CW'(IDEPTH);
  assign mem_hit_c   = {1'b0, mem_addr} < CW'(DDEPTH);
  // A restart pulse wins over a word presented in the same cycle.
  assign accept_c    = (state_q == ST_LOAD) && ld_ready_q && ld_valid && !ld_start;
  assign last_slot_c = (load_count_q == CW'(IDEPTH - 1));
  assign dmem_we_c   = run_c && mem_ctrl && mem_hit_c;

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_HOLD;
      cpu_rst_q    <= 1'b1;
      ld_ready_q   <= 1'b0;
      load_count_q <= '0;
      wr_count_q   <= '0;
      oob_err_q    <= 1'b0;
      ld_ovf_q     <= 1'b0;
    end else begin
      if (dmem_we_c && (wr_count_q != 16'hFFFF)) begin
        wr_count_q <= wr_count_q + 16'd1;
      end
      if (run_c && !mem_hit_c) begin
        oob_err_q <= 1'b1;
      end

      if (ld_start) begin
        // Entering (or restarting) a load clears the sticky flags.
        state_q      <= ST_LOAD;
        cpu_rst_q    <= 1'b1;
        ld_ready_q   <= 1'b1;
        load_count_q <= '0;
        oob_err_q    <= 1'b0;
        ld_ovf_q     <= 1'b0;
      end else begin
        unique case (state_q)
          ST_HOLD: begin
            if (go) begin
              state_q   <= ST_RUN;
              cpu_rst_q <= 1'b0;
            end
          end
          ST_LOAD: begin
            if (accept_c) begin
              load_count_q <= load_count_q + CW'(1);
              if (ld_last || last_slot_c) begin
                state_q    <= ST_RUN;
                cpu_rst_q  <= 1'b0;
                ld_ready_q <= 1'b0;
                ld_ovf_q   <= !ld_last;
              end
            end
          end
          ST_RUN: begin
            state_q <= ST_RUN;
          end
          default: begin
            state_q    <= ST_HOLD;
            cpu_rst_q  <= 1'b1;
            ld_ready_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Storage is deliberately not reset so a reset mid-load keeps written words.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      imem_q[load_count_q[IAW-1:0]] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (dmem_we_c) begin
      dmem_q[mem_addr[DAW-1:0]] <= mem_wdata;
    end
  end

  assign ins_data   = (run_c && ins_hit_c) ? imem_q[ins_addr[IAW-1:0]] : '0;
  assign mem_rdata  = (run_c && mem_hit_c) ? dmem_q[mem_addr[DAW-1:0]] : '0;

  assign cpu_rst    = cpu_rst_q;
  assign ld_ready   = ld_ready_q;
  assign load_count = load_count_q;
  assign wr_count   = wr_count_q;
  assign oob_err    = oob_err_q;
  assign ld_ovf     = ld_ovf_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed + randomized bench for cpu_mem_responder against a simple memory model.
module tb_cpu_mem_responder;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned ADDRSIZE = 12;
  localparam int unsigned IDEPTH   = 256;
  localparam int unsigned DDEPTH   = 256;

  logic                clk = 1'b0;
  logic                rst;
  logic [ADDRSIZE-1:0] mem_addr;
  logic [0:WIDTH-1]    mem_wdata;
  logic                mem_ctrl;
  logic [0:WIDTH-1]    mem_rdata;
  logic [ADDRSIZE-1:0] ins_addr;
  logic [0:WIDTH-1]    ins_data;
  logic                ld_start;
  logic                ld_valid;
  logic [0:WIDTH-1]    ld_data;
  logic                ld_last;
  logic                ld_ready;
  logic                go;
  logic                cpu_rst;
  logic [ADDRSIZE:0]   load_count;
  logic [15:0]         wr_count;
  logic                oob_err;
  logic                ld_ovf;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] imem_m [IDEPTH];
  logic [31:0] dmem_m [DDEPTH];
  bit          dknown [DDEPTH];
  int          wcnt;

  cpu_mem_responder #(
    .WIDTH(WIDTH), .ADDRSIZE(ADDRSIZE), .IDEPTH(IDEPTH), .DDEPTH(DDEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ctrl(mem_ctrl), .mem_rdata(mem_rdata),
    .ins_addr(ins_addr), .ins_data(ins_data),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .go(go), .cpu_rst(cpu_rst), .load_count(load_count),
    .wr_count(wr_count), .oob_err(oob_err), .ld_ovf(ld_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] w4 [4];
    logic [31:0] old5, n0, n1, v;
    int a;
    w4[0] = 32'h40001001; w4[1] = 32'h20005002; w4[2] = 32'h10000000; w4[3] = 32'h90000000;
    wcnt = 0;
    for (int i = 0; i < int'(DDEPTH); i++) dknown[i] = 1'b0;

    rst = 1'b1; mem_addr = '0; mem_wdata = '0; mem_ctrl = 1'b0; ins_addr = '0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; go = 1'b0;
    tick(); tick();
    chk("rst_cpu_rst",    64'(cpu_rst), 64'(1));
    chk("rst_ld_ready",   64'(ld_ready), 64'(0));
    chk("rst_load_count", 64'(load_count), 64'(0));
    chk("rst_wr_count",   64'(wr_count), 64'(0));
    chk("rst_oob",        64'(oob_err), 64'(0));
    chk("rst_ovf",        64'(ld_ovf), 64'(0));
    chk("rst_ins_data",   64'(ins_data), 64'(0));
    chk("rst_mem_rdata",  64'(mem_rdata), 64'(0));
    rst = 1'b0;

    // Four-word program terminated by ld_last.
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    chk("ld4_ready_up", 64'(ld_ready), 64'(1));
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = w4[i]; ld_last = (i == 3);
      if (i == 3) begin
        #1 chk("ld4_cpu_rst_before_last", 64'(cpu_rst), 64'(1));
      end
      tick();
      imem_m[i] = w4[i];
      chk("ld4_count", 64'(load_count), 64'(i + 1));
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("ld4_cpu_rst_fall", 64'(cpu_rst), 64'(0));
    chk("ld4_ready_fall",   64'(ld_ready), 64'(0));
    chk("ld4_ovf",          64'(ld_ovf), 64'(0));
    ins_addr = 12'd2; #1;
    chk("ld4_ins2", 64'(ins_data), 64'(32'h10000000));
    for (int i = 0; i < 4; i++) begin
      ins_addr = 12'(i); #1;
      chk("ld4_ins_rand", 64'(ins_data), 64'(imem_m[i]));
    end
    ins_addr = 12'd300; #1;
    chk("ins_oob_zero", 64'(ins_data), 64'(0));
    chk("ins_oob_no_err", 64'(oob_err), 64'(0));

    // Data write then read-back, and old data visible during a write.
    mem_addr = 12'd5; mem_wdata = 32'hDEADBEEF; mem_ctrl = 1'b1;
    tick(); mem_ctrl = 1'b0; #1;
    dmem_m[5] = 32'hDEADBEEF; dknown[5] = 1'b1; wcnt++;
    chk("wr5_readback", 64'(mem_rdata), 64'(32'hDEADBEEF));
    chk("wr5_count",    64'(wr_count), 64'(1));
    old5 = $urandom;
    mem_wdata = old5; mem_ctrl = 1'b1; #1;
    chk("rdw_old", 64'(mem_rdata), 64'(32'hDEADBEEF));
    tick(); mem_ctrl = 1'b0; #1;
    dmem_m[5] = old5; wcnt++;
    chk("rdw_new", 64'(mem_rdata), 64'(old5));

    // Random in-range traffic against the model.
    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(0, 15));
      v = $urandom;
      mem_addr = 12'(a); mem_wdata = v; mem_ctrl = 1'($urandom_range(0, 1)); #1;
      if (dknown[a]) chk("rand_rd", 64'(mem_rdata), 64'(dmem_m[a]));
      tick();
      if (mem_ctrl) begin
        dmem_m[a] = v; dknown[a] = 1'b1; wcnt++;
      end
    end
    mem_ctrl = 1'b0;
    chk("rand_wr_count", 64'(wr_count), 64'(wcnt));
    chk("rand_no_oob",   64'(oob_err), 64'(0));

    // Out-of-range write: dropped, sticky error, no alias onto addr 44.
    mem_addr = 12'd44; mem_wdata = 32'h0BADF00D; mem_ctrl = 1'b1;
    tick(); dmem_m[44] = 32'h0BADF00D; dknown[44] = 1'b1; wcnt++;
    mem_addr = 12'd300; mem_wdata = 32'hCAFEF00D; #1;
    chk("oob_rd_zero", 64'(mem_rdata), 64'(0));
    tick(); mem_ctrl = 1'b0; mem_addr = 12'd44;
    chk("oob_set",      64'(oob_err), 64'(1));
    chk("oob_wr_count", 64'(wr_count), 64'(wcnt));
    #1 chk("oob_no_alias", 64'(mem_rdata), 64'(dmem_m[44]));
    tick(); tick();
    chk("oob_sticky", 64'(oob_err), 64'(1));

    // Reprogram from RUN with a 256-word load lacking ld_last.
    ins_addr = 12'd2; mem_addr = 12'd5;
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    chk("re_oob_clear", 64'(oob_err), 64'(0));
    chk("re_cpu_rst",   64'(cpu_rst), 64'(1));
    chk("re_ins_zero",  64'(ins_data), 64'(0));
    chk("re_rd_zero",   64'(mem_rdata), 64'(0));
    chk("re_count0",    64'(load_count), 64'(0));
    for (int i = 0; i < int'(IDEPTH); i++) begin
      v = $urandom;
      ld_valid = 1'b1; ld_data = v;
      tick();
      imem_m[i] = v;
      if (i == int'(IDEPTH) - 2) begin
        chk("ovf_pre_count", 64'(load_count), 64'(IDEPTH - 1));
        chk("ovf_pre_flag",  64'(ld_ovf), 64'(0));
        chk("ovf_pre_ready", 64'(ld_ready), 64'(1));
      end
    end
    chk("ovf_flag",    64'(ld_ovf), 64'(1));
    chk("ovf_count",   64'(load_count), 64'(IDEPTH));
    chk("ovf_cpu_rst", 64'(cpu_rst), 64'(0));
    chk("ovf_ready",   64'(ld_ready), 64'(0));
    ld_data = 32'h5555AAAA; tick(); ld_valid = 1'b0;
    chk("ovf_no_more", 64'(load_count), 64'(IDEPTH));
    ins_addr = 12'd0; #1;
    chk("ovf_word0", 64'(ins_data), 64'(imem_m[0]));
    for (int i = 0; i < 12; i++) begin
      a = int'($urandom_range(0, IDEPTH - 1));
      ins_addr = 12'(a); #1;
      chk("ovf_ins_rand", 64'(ins_data), 64'(imem_m[a]));
    end
    chk("ovf_wr_count_kept", 64'(wr_count), 64'(wcnt));

    // Reprogram interrupted by async reset after two words.
    ins_addr = 12'd0;
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    chk("rp_cpu_rst", 64'(cpu_rst), 64'(1));
    chk("rp_ins_zero", 64'(ins_data), 64'(0));
    n0 = $urandom; n1 = $urandom;
    ld_valid = 1'b1; ld_data = n0; tick(); imem_m[0] = n0;
    ld_data = n1; tick(); imem_m[1] = n1;
    ld_valid = 1'b0;
    chk("rp_count2", 64'(load_count), 64'(2));
    #2 rst = 1'b1; #1;
    chk("arst_cpu_rst", 64'(cpu_rst), 64'(1));
    chk("arst_ready",   64'(ld_ready), 64'(0));
    chk("arst_count",   64'(load_count), 64'(0));
    chk("arst_wr",      64'(wr_count), 64'(0));
    tick(); rst = 1'b0;

    // HOLD ignores loader traffic; go releases in one cycle.
    ld_valid = 1'b1; ld_last = 1'b1; ld_data = 32'h77777777;
    tick(); tick(); tick();
    chk("hold_ready", 64'(ld_ready), 64'(0));
    chk("hold_count", 64'(load_count), 64'(0));
    chk("hold_cpu_rst", 64'(cpu_rst), 64'(1));
    ld_valid = 1'b0; ld_last = 1'b0; go = 1'b1;
    tick(); go = 1'b0;
    chk("go_cpu_rst", 64'(cpu_rst), 64'(0));
    ins_addr = 12'd0; #1 chk("go_ins0", 64'(ins_data), 64'(n0));
    ins_addr = 12'd1; #1 chk("go_ins1", 64'(ins_data), 64'(n1));
    ins_addr = 12'd2; #1 chk("go_ins2", 64'(ins_data), 64'(imem_m[2]));
    mem_addr = 12'd44; #1 chk("go_dmem_kept", 64'(mem_rdata), 64'(dmem_m[44]));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
